// File: rtl/hs_pkg.sv
// Shared definitions for the CPU send/ack handshake responder.
// The data width must match the CPU side of the link.
package hs_pkg;

    typedef enum logic {S_IDLE, S_ACK} hs_state_t;

    localparam int HS_DW = 4;

endpackage

// File: rtl/hs_fifo_mem.sv
// Small synchronous FIFO: storage array, wrapping pointers and occupancy count.
// The head entry is read combinationally, so a word written at one edge is visible right after it.
module hs_fifo_mem #(
    parameter int DW    = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Guard against overflow/underflow even if a caller requests an illegal operation.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_push  = push && !w_full;
    assign w_pop   = pop && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rdPtr];
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: rtl/hs_rx_fifo.sv
// Peripheral-side responder for the CPU four-phase send/ack handshake.
// Each handshake captures one word into a FIFO drained by a valid/ready consumer.
module hs_rx_fifo
    import hs_pkg::*;
#(
    parameter int DW    = HS_DW,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    send,
    input  logic [DW-1:0]           data,
    output logic                    ack,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);

    hs_state_t r_state;
    hs_state_t w_nextState;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_count;
    logic [DW-1:0] w_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Exactly one write per handshake: only on the S_IDLE->S_ACK edge, and never while full.
    always_comb begin
        w_nextState = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (send && !w_full) begin
                    w_push      = 1'b1;
                    w_nextState = S_ACK;
                end
            end
            S_ACK: begin
                if (!send) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    assign w_pop = !w_empty && out_ready;

    hs_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (data),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign ack       = (r_state == S_ACK);
    assign out_valid = !w_empty;
    assign out_data  = w_rdata;
    assign count     = w_count;
    assign full      = w_full;

endmodule

// File: tb/tb_hs_rx_fifo.sv
// Self-checking bench for hs_rx_fifo: vector table, directed corner sequences,
// and randomized traffic compared against a queue-based model of the handshake rules.
module tb_hs_rx_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       send;
    logic [3:0] data;
    logic       ack;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] count;
    logic       full;

    int checks;
    int errors;

    logic [3:0] mQ[$];
    bit         mAck;

    typedef struct {
        bit         rst;
        bit         send;
        logic [3:0] data;
        bit         ready;
        bit         expAck;
        bit         expValid;
        int         expCount;
        bit         expFull;
        logic [3:0] expData;
    } vec_t;

    vec_t vecs[21];

    hs_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .data      (data),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle past the edge.
    task automatic applyStimulus(input bit r, input bit s, input logic [3:0] d, input bit rdy);
        bit fullBefore;
        bit popNow;
        bit pushNow;
        rst       = r;
        send      = s;
        data      = d;
        out_ready = rdy;
        @(posedge clk);
        fullBefore = (mQ.size() == DEPTH);
        popNow     = (mQ.size() > 0) && rdy;
        pushNow    = !mAck && s && !fullBefore;
        if (r) begin
            mQ.delete();
            mAck = 1'b0;
        end else begin
            if (popNow) void'(mQ.pop_front());
            if (pushNow) mQ.push_back(d);
            mAck = mAck ? s : pushNow;
        end
        #1;
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, ".ack"}, int'(ack), int'(mAck));
        checkVal({name, ".valid"}, int'(out_valid), int'(mQ.size() > 0));
        checkVal({name, ".count"}, int'(count), mQ.size());
        checkVal({name, ".full"}, int'(full), int'(mQ.size() == DEPTH));
        if (mQ.size() > 0) begin
            checkVal({name, ".data"}, int'(out_data), int'(mQ[0]));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mAck      = 1'b0;
        rst       = 1'b1;
        send      = 1'b0;
        data      = 4'h0;
        out_ready = 1'b0;

        //           rst snd data  rdy  ack vld cnt full head
        vecs[0]  = '{1, 0, 4'h0, 0,   0, 0, 0, 0, 4'h0};
        vecs[1]  = '{0, 1, 4'hC, 0,   1, 1, 1, 0, 4'hC};
        vecs[2]  = '{0, 0, 4'hC, 0,   0, 1, 1, 0, 4'hC};
        vecs[3]  = '{0, 0, 4'h0, 1,   0, 0, 0, 0, 4'h0};
        vecs[4]  = '{0, 1, 4'h1, 0,   1, 1, 1, 0, 4'h1};
        vecs[5]  = '{0, 0, 4'h1, 0,   0, 1, 1, 0, 4'h1};
        vecs[6]  = '{0, 1, 4'h2, 0,   1, 1, 2, 0, 4'h1};
        vecs[7]  = '{0, 0, 4'h2, 0,   0, 1, 2, 0, 4'h1};
        vecs[8]  = '{0, 1, 4'h3, 0,   1, 1, 3, 0, 4'h1};
        vecs[9]  = '{0, 0, 4'h3, 0,   0, 1, 3, 0, 4'h1};
        vecs[10] = '{0, 1, 4'h4, 0,   1, 1, 4, 1, 4'h1};
        vecs[11] = '{0, 0, 4'h4, 0,   0, 1, 4, 1, 4'h1};
        vecs[12] = '{0, 1, 4'h5, 0,   0, 1, 4, 1, 4'h1};
        vecs[13] = '{0, 1, 4'h5, 0,   0, 1, 4, 1, 4'h1};
        vecs[14] = '{0, 1, 4'h5, 1,   0, 1, 3, 0, 4'h2};
        vecs[15] = '{0, 1, 4'h5, 0,   1, 1, 4, 1, 4'h2};
        vecs[16] = '{0, 0, 4'h5, 0,   0, 1, 4, 1, 4'h2};
        vecs[17] = '{0, 0, 4'h0, 1,   0, 1, 3, 0, 4'h3};
        vecs[18] = '{0, 0, 4'h0, 1,   0, 1, 2, 0, 4'h4};
        vecs[19] = '{0, 0, 4'h0, 1,   0, 1, 1, 0, 4'h5};
        vecs[20] = '{0, 0, 4'h0, 1,   0, 0, 0, 0, 4'h0};

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].send, vecs[i].data, vecs[i].ready);
            checkVal($sformatf("vec%0d.ack", i), int'(ack), int'(vecs[i].expAck));
            checkVal($sformatf("vec%0d.valid", i), int'(out_valid), int'(vecs[i].expValid));
            checkVal($sformatf("vec%0d.count", i), int'(count), vecs[i].expCount);
            checkVal($sformatf("vec%0d.full", i), int'(full), int'(vecs[i].expFull));
            if (vecs[i].expValid) begin
                checkVal($sformatf("vec%0d.data", i), int'(out_data), int'(vecs[i].expData));
            end
        end

        // Drain with consumer always ready: occupancy never goes past one, pointers wrap.
        for (int w = 9; w <= 14; w++) begin
            applyStimulus(1'b0, 1'b1, 4'(w), 1'b1);
            checkVal("drain.pushCount", int'(count), 1);
            checkVal("drain.pushData", int'(out_data), w);
            checkOutput("drain.push");
            applyStimulus(1'b0, 1'b0, 4'(w), 1'b1);
            checkVal("drain.popCount", int'(count), 0);
            checkOutput("drain.pop");
        end

        // Push and pop on the same edge keep the count and preserve order.
        applyStimulus(1'b0, 1'b1, 4'h3, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h3, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h5, 1'b0);
        checkVal("simul.preCount", int'(count), 2);
        checkVal("simul.preHead", int'(out_data), 3);
        applyStimulus(1'b0, 1'b1, 4'h7, 1'b1);
        checkVal("simul.count", int'(count), 2);
        checkVal("simul.head", int'(out_data), 5);
        checkOutput("simul");
        applyStimulus(1'b0, 1'b0, 4'h7, 1'b1);
        checkVal("simul.nextHead", int'(out_data), 7);
        checkOutput("simul.next");
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        checkOutput("simul.empty");

        // Held send: one write only, ack stays high until send drops, data changes ignored.
        applyStimulus(1'b0, 1'b1, 4'hA, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 4'hB, 1'b0);
            checkVal("held.count", int'(count), 1);
            checkVal("held.ack", int'(ack), 1);
            checkVal("held.head", int'(out_data), 10);
        end
        applyStimulus(1'b0, 1'b0, 4'hB, 1'b0);
        checkVal("held.ackDrop", int'(ack), 0);
        checkOutput("held.release");
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        checkOutput("held.drain");

        // Reset in the middle of a handshake with three words queued.
        applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h2, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h2, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h3, 1'b0);
        checkVal("rstMid.preCount", int'(count), 3);
        checkVal("rstMid.preAck", int'(ack), 1);
        applyStimulus(1'b1, 1'b1, 4'h3, 1'b0);
        checkVal("rstMid.ack", int'(ack), 0);
        checkVal("rstMid.count", int'(count), 0);
        checkVal("rstMid.valid", int'(out_valid), 0);
        applyStimulus(1'b0, 1'b1, 4'h6, 1'b0);
        checkVal("rstMid.recapAck", int'(ack), 1);
        checkVal("rstMid.recapCount", int'(count), 1);
        checkVal("rstMid.recapData", int'(out_data), 6);
        applyStimulus(1'b0, 1'b0, 4'h6, 1'b0);
        checkOutput("rstMid.release");
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        checkOutput("rstMid.drain");

        // Randomized traffic against the queue model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 2) != 0,
                          4'($urandom),
                          $urandom_range(0, 1) == 1);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
